// File: rtl/intc_if.sv
// Bus bundle between the CPU-side ports and the intc interrupt controller.
// The master drives requests, mask and ack; the slave (intc) returns inter and status.
interface intc_if;
  logic [3:0] ext_irq;
  logic [7:0] mask_in;
  logic [7:0] ack_in;
  logic       inter;
  logic [7:0] status_out;

  modport master (
    output ext_irq, mask_in, ack_in,
    input  inter, status_out
  );

  modport slave (
    input  ext_irq, mask_in, ack_in,
    output inter, status_out
  );
endinterface

// File: rtl/intc.sv
// Four-source interrupt controller with sticky pending bits, mask, ack-edge clear and status byte.
// Optional feature macro: INTC_TIMER_EN makes source 3 an internal periodic timer.
module intc #(
  parameter int TIMER_DIV = 50000
) (
  input  logic   clk,
  input  logic   reset,
  intc_if.slave  bus
);

  logic [3:0] sync1_r;
  logic [3:0] sync2_r;
  logic [3:0] prev_r;
  logic       ack_prev_r;
  logic [3:0] pending_r;
  logic       lost_r;
  logic       inter_r;
  logic [7:0] status_r;

  logic [3:0] rise_s;
  logic       ack_s;
  logic [3:0] clr_s;
  logic [3:0] set_s;
  logic [3:0] active_s;
  logic [1:0] idx_s;
  logic [3:0] pending_next_s;
  logic       lost_next_s;

  assign rise_s = sync2_r & ~prev_r;
  assign ack_s  = bus.ack_in[7] & ~ack_prev_r;
  assign clr_s  = ack_s ? bus.ack_in[3:0] : 4'b0000;

`ifdef INTC_TIMER_EN
  localparam int CW = $clog2(TIMER_DIV);
  localparam logic [CW-1:0] LAST = CW'(TIMER_DIV - 1);

  logic [CW-1:0] count_r;
  logic          tick_s;

  // The tick fires on the edge where the counter wraps back to zero.
  assign tick_s = (count_r == LAST);
  assign set_s  = {tick_s, rise_s[2:0]};

  // Free-running period counter, phase restarted by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {CW{1'b0}};
    end else if (tick_s) begin
      count_r <= {CW{1'b0}};
    end else begin
      count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end
`else
  assign set_s = rise_s;
`endif

  // Set wins over clear for both pending bits and the overrun flag.
  always_comb begin
    pending_next_s = (pending_r & ~clr_s) | set_s;
    lost_next_s    = (set_s[3] & pending_r[3]) | (lost_r & ~clr_s[3]);
  end

  assign active_s = pending_r & bus.mask_in[3:0];

  // Lowest-numbered active source has priority.
  always_comb begin
    idx_s = 2'd0;
    if (active_s[0]) begin
      idx_s = 2'd0;
    end else if (active_s[1]) begin
      idx_s = 2'd1;
    end else if (active_s[2]) begin
      idx_s = 2'd2;
    end else if (active_s[3]) begin
      idx_s = 2'd3;
    end else begin
      idx_s = 2'd0;
    end
  end

  // Synchronisers, edge detectors, pending state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r    <= 4'b0000;
      sync2_r    <= 4'b0000;
      prev_r     <= 4'b0000;
      ack_prev_r <= 1'b0;
      pending_r  <= 4'b0000;
      lost_r     <= 1'b0;
      inter_r    <= 1'b0;
      status_r   <= 8'h00;
    end else begin
      sync1_r    <= bus.ext_irq;
      sync2_r    <= sync1_r;
      prev_r     <= sync2_r;
      ack_prev_r <= bus.ack_in[7];
      pending_r  <= pending_next_s;
      lost_r     <= lost_next_s;
      inter_r    <= |active_s;
      status_r   <= {lost_r, |active_s, idx_s, pending_r};
    end
  end

  assign bus.inter      = inter_r;
  assign bus.status_out = status_r;

endmodule

// File: tb/tb_intc.sv
// Directed self-checking bench for intc; exercises the timer path when INTC_TIMER_EN is defined.
module tb_intc;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  logic seen;

  intc_if bus ();

  intc #(.TIMER_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    seen  = 1'b0;
    reset = 1'b1;
    bus.ext_irq = 4'h0;
    bus.mask_in = 8'h00;
    bus.ack_in  = 8'h00;

`ifdef INTC_TIMER_EN
    bus.mask_in = 8'h08;
    step();
    check("rst_inter", {7'b0, bus.inter}, 8'h00);
    check("rst_status", bus.status_out, 8'h00);
    reset = 1'b0;
    step(); step(); step();
    check("tmr_e3_status", bus.status_out, 8'h00);
    step();
    check("tmr_e4_inter", {7'b0, bus.inter}, 8'h00);
    step();
    check("tmr_e5_inter", {7'b0, bus.inter}, 8'h01);
    check("tmr_e5_status", bus.status_out, 8'h78);
    step(); step(); step();
    check("tmr_e8_status", bus.status_out, 8'h78);
    step();
    check("tmr_lost", bus.status_out, 8'hF8);
    bus.ack_in = 8'h88;
    step(); step();
    check("tmr_ack_status", bus.status_out, 8'h00);
    check("tmr_ack_inter", {7'b0, bus.inter}, 8'h00);
    bus.ack_in = 8'h00;
    step(); step();
    check("tmr_next_period", bus.status_out, 8'h78);
    reset = 1'b1;
    step();
    check("tmr_midrst", bus.status_out, 8'h00);
    reset = 1'b0;
    step(); step(); step(); step();
    check("tmr_phase_e4", bus.status_out, 8'h00);
    step();
    check("tmr_phase_e5", bus.status_out, 8'h78);
`else
    bus.ext_irq = 4'hF;
    step();
    check("rst_inter", {7'b0, bus.inter}, 8'h00);
    check("rst_status", bus.status_out, 8'h00);
    reset = 1'b0;
    step(); step(); step();
    check("rel_latency", bus.status_out, 8'h00);
    step();
    check("rel_edges", bus.status_out, 8'h0F);
    check("rel_inter_masked", {7'b0, bus.inter}, 8'h00);
    bus.ack_in = 8'h8F;
    step(); step();
    check("rel_cleared", bus.status_out, 8'h00);
    step(); step();
    check("rel_single_edge", bus.status_out, 8'h00);
    bus.ext_irq = 4'h0;
    bus.ack_in  = 8'h00;
    step();

    // External source 0 path and ack latency.
    bus.mask_in = 8'h01;
    bus.ext_irq = 4'h1;
    step();
    bus.ext_irq = 4'h0;
    step(); step();
    check("ext_n2_status", bus.status_out, 8'h00);
    step();
    check("ext_n3_status", bus.status_out, 8'h41);
    check("ext_n3_inter", {7'b0, bus.inter}, 8'h01);
    bus.ack_in = 8'h81;
    step();
    check("ack_m1_inter", {7'b0, bus.inter}, 8'h01);
    step();
    check("ack_m2_inter", {7'b0, bus.inter}, 8'h00);
    check("ack_m2_status", bus.status_out, 8'h00);

    // Holding ack bit 7 high must not clear a new request.
    bus.ext_irq = 4'h1;
    step();
    bus.ext_irq = 4'h0;
    step(); step(); step();
    check("ack_held", bus.status_out, 8'h41);
    bus.ack_in = 8'h00;
    step();
    bus.ack_in = 8'h81;
    step(); step();
    check("ack_reedge", bus.status_out, 8'h00);
    bus.ack_in = 8'h00;
    step();

    // Masked sources stay pending; unmasking reports lowest index.
    bus.mask_in = 8'h00;
    bus.ext_irq = 4'h6;
    step();
    bus.ext_irq = 4'h0;
    step(); step(); step();
    check("mask_status", bus.status_out, 8'h06);
    check("mask_inter", {7'b0, bus.inter}, 8'h00);
    bus.mask_in = 8'h06;
    step();
    check("unmask_inter", {7'b0, bus.inter}, 8'h01);
    check("unmask_status", bus.status_out, 8'h56);

    // Re-edge on source 1 lands in the same cycle as an ack clearing 1 and 2.
    bus.ext_irq = 4'h2;
    step();
    bus.ext_irq = 4'h0;
    step();
    bus.ack_in = 8'h86;
    step(); step();
    check("setwins_status", bus.status_out, 8'h52);
    check("setwins_inter", {7'b0, bus.inter}, 8'h01);
    bus.ack_in = 8'h00;
    step();
    bus.ack_in = 8'h8F;
    step(); step();
    check("clear_all", bus.status_out, 8'h00);
    bus.ack_in = 8'h00;
    step();

    // No internal timer in this build.
    bus.mask_in = 8'h08;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus.inter !== 1'b0 || bus.status_out !== 8'h00) seen = 1'b1;
    end
    check("no_tick", {7'b0, seen}, 8'h00);

    // Source 3 as an external line, including overrun flag.
    bus.ext_irq = 4'h8;
    step();
    bus.ext_irq = 4'h0;
    step(); step();
    check("src3_n2", bus.status_out, 8'h00);
    step();
    check("src3_n3", bus.status_out, 8'h78);
    check("src3_inter", {7'b0, bus.inter}, 8'h01);
    bus.ext_irq = 4'h8;
    step();
    bus.ext_irq = 4'h0;
    step(); step(); step();
    check("src3_lost", bus.status_out, 8'hF8);
    bus.ack_in = 8'h88;
    step(); step();
    check("src3_ack_status", bus.status_out, 8'h00);
    check("src3_ack_inter", {7'b0, bus.inter}, 8'h00);
    bus.ack_in = 8'h00;
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
